serial_adder_ctrl: RTL and testbench

//  Bit-serial add sequencer. Time-shares ONE 1-bit full_adder instance over WIDTH-bit operands,
//  LSB first, one bit per clock, with a carry flip-flop between bits.

---
 rtl/serial_adder_ctrl.sv | 128 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add sequencer; one full-adder bit per clock, LSB first.
// Optional macro OVERFLOW_DETECT_EN adds ovf_out (signed overflow of the completed add).
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
`ifdef OVERFLOW_DETECT_EN
    output logic             carry_out,
    output logic             ovf_out
`else
    output logic             carry_out
`endif
);
    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cff_q, cff_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             fa_s, fa_co;
    logic [WIDTH-1:0] psum_shift;
    logic             last_bit;

    // The single time-shared full adder.
    assign fa_s     = a_sh_q[0] ^ b_sh_q[0] ^ cff_q;
    assign fa_co    = (a_sh_q[0] & b_sh_q[0]) | (cff_q & (a_sh_q[0] ^ b_sh_q[0]));
    assign last_bit = (cnt_q == CntW'(WIDTH - 1));

    generate
        if (WIDTH == 1) begin : g_w1
            assign psum_shift = fa_s;
        end else begin : g_wn
            assign psum_shift = {fa_s, psum_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cff_d   = cff_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StAdd: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                psum_d = psum_shift;
                cff_d  = fa_co;
                cnt_d  = cnt_q + CntW'(1);
                if (last_bit) begin
                    sum_d   = psum_shift;
                    carry_d = fa_co;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: ;
        endcase
        // Accept from IDLE, or straight out of DONE for back-to-back adds.
        if (start_in && (state_q != StAdd)) begin
            a_sh_d  = a_in;
            b_sh_d  = b_in;
            cff_d   = c_in;
            cnt_d   = '0;
            state_d = StAdd;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cff_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cff_q   <= cff_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_out  = (state_q == StAdd);
    assign done_out  = (state_q == StDone);
    assign sum_out   = sum_q;
    assign carry_out = carry_q;

`ifdef OVERFLOW_DETECT_EN
    logic ovf_q;

    // On the final bit, cff_q is the carry into the MSB.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ovf_q <= 1'b0;
        end else if ((state_q == StAdd) && last_bit) begin
            ovf_q <= cff_q ^ fa_co;
        end
    end

    assign ovf_out = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: WIDTH=8 main instance plus a WIDTH=1 instance.
module tb_serial_adder_ctrl;
    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
    } exp_t;

    logic         clock = 1'b0;
    logic         resetn;
    logic         start;
    logic [W-1:0] a_in, b_in;
    logic         c_in;
    logic         busy, done, carry, ovf;
    logic [W-1:0] sum;

    logic s1_start, s1_a, s1_b, s1_c, s1_busy, s1_done, s1_sum, s1_carry, s1_ovf;

    exp_t sb[$];
    exp_t last;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .start_in (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .c_in     (c_in),
        .busy_out (busy),
        .done_out (done),
        .sum_out  (sum),
`ifdef OVERFLOW_DETECT_EN
        .carry_out(carry),
        .ovf_out  (ovf)
`else
        .carry_out(carry)
`endif
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clock    (clock),
        .resetn   (resetn),
        .start_in (s1_start),
        .a_in     (s1_a),
        .b_in     (s1_b),
        .c_in     (s1_c),
        .busy_out (s1_busy),
        .done_out (s1_done),
        .sum_out  (s1_sum),
`ifdef OVERFLOW_DETECT_EN
        .carry_out(s1_carry),
        .ovf_out  (s1_ovf)
`else
        .carry_out(s1_carry)
`endif
    );

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c);
        logic [W:0] r;
        exp_t       e;
        r       = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        e.sum   = r[W-1:0];
        e.carry = r[W];
        e.ovf   = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
        return e;
    endfunction

    // One add; optionally pulses start again at ADD cycle inject_k with other operands.
    task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                           input int inject_k);
        exp_t e;
        @(negedge clock);
        start = 1'b1; a_in = a; b_in = b; c_in = c;
        sb.push_back(model(a, b, c));
        @(posedge clock);
        for (int k = 0; k < int'(W); k++) begin
            @(negedge clock);
            start = (k == inject_k);
            if (k == inject_k) begin
                a_in = ~a; b_in = a; c_in = ~c;
            end
            n_vec++;
            if (busy !== 1'b1 || done !== 1'b0 || sum !== last.sum || carry !== last.carry) begin
                n_err++;
                $display("FAIL add_busy k=%0d: busy=%b done=%b sum=%h carry=%b, need 1 0 %h %b",
                         k, busy, done, sum, carry, last.sum, last.carry);
            end
            @(posedge clock);
        end
        @(negedge clock);
        start = 1'b0;
        e = sb.pop_front();
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0 || sum !== e.sum || carry !== e.carry) begin
            n_err++;
            $display("FAIL add_result %h+%h+%b: done=%b busy=%b sum=%h carry=%b, need 1 0 %h %b",
                     a, b, c, done, busy, sum, carry, e.sum, e.carry);
        end
`ifdef OVERFLOW_DETECT_EN
        n_vec++;
        if (ovf !== e.ovf) begin
            n_err++;
            $display("FAIL add_ovf %h+%h+%b: ovf=%b, need %b", a, b, c, ovf, e.ovf);
        end
`endif
        last = e;
        @(posedge clock);
        @(negedge clock);
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== e.sum) begin
            n_err++;
            $display("FAIL done_pulse: done=%b busy=%b sum=%h, need 0 0 %h", done, busy, sum, e.sum);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; a_in = '0; b_in = '0; c_in = 1'b0;
        s1_start = 1'b0; s1_a = 1'b0; s1_b = 1'b0; s1_c = 1'b0;
        last = '0;
        #12;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || carry !== 1'b0 ||
            s1_busy !== 1'b0 || s1_done !== 1'b0 || s1_sum !== 1'b0 || s1_carry !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b sum=%h carry=%b w1=%b%b%b%b, need all 0",
                     busy, done, sum, carry, s1_busy, s1_done, s1_sum, s1_carry);
        end
`ifdef OVERFLOW_DETECT_EN
        n_vec++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ovf: ovf=%b, need 0", ovf);
        end
`endif
        @(negedge clock);
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: busy=%b done=%b, need 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        run_add(8'h35, 8'h4A, 1'b0, -1);
        run_add(8'hFF, 8'h01, 1'b0, -1);
        run_add(8'hFF, 8'hFF, 1'b1, -1);
        for (int i = 0; i < 6; i++) begin
            run_add(W'($urandom), W'($urandom), 1'($urandom), -1);
        end
    endtask

    task automatic test_ignore_start();
        run_add(8'h5C, 8'h21, 1'b1, 3);
    endtask

    task automatic test_back_to_back();
        exp_t e1, e2, got;
        e1 = model(8'hA5, 8'h3C, 1'b1);
        e2 = model(8'h12, 8'hF0, 1'b0);
        @(negedge clock);
        start = 1'b1; a_in = 8'hA5; b_in = 8'h3C; c_in = 1'b1;
        sb.push_back(e1);
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (W - 1) @(posedge clock);
        @(negedge clock);
        start = 1'b1; a_in = 8'h12; b_in = 8'hF0; c_in = 1'b0;
        sb.push_back(e2);
        @(posedge clock);
        @(negedge clock);
        got = sb.pop_front();
        n_vec++;
        if (done !== 1'b1 || sum !== got.sum || carry !== got.carry) begin
            n_err++;
            $display("FAIL b2b_first: done=%b sum=%h carry=%b, need 1 %h %b",
                     done, sum, carry, got.sum, got.carry);
        end
        @(posedge clock);
        for (int k = 0; k < int'(W); k++) begin
            @(negedge clock);
            start = 1'b0;
            n_vec++;
            if (busy !== 1'b1 || done !== 1'b0 || sum !== e1.sum) begin
                n_err++;
                $display("FAIL b2b_hold k=%0d: busy=%b done=%b sum=%h, need 1 0 %h",
                         k, busy, done, sum, e1.sum);
            end
            @(posedge clock);
        end
        @(negedge clock);
        got = sb.pop_front();
        n_vec++;
        if (done !== 1'b1 || sum !== got.sum || carry !== got.carry) begin
            n_err++;
            $display("FAIL b2b_second: done=%b sum=%h carry=%b, need 1 %h %b",
                     done, sum, carry, got.sum, got.carry);
        end
        last = got;
        @(posedge clock);
        @(negedge clock);
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end: done=%b busy=%b, need 0 0", done, busy);
        end
    endtask

    task automatic test_reset_mid_add();
        int seen_done;
        @(negedge clock);
        start = 1'b1; a_in = 8'h0F; b_in = 8'h0F; c_in = 1'b0;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || carry !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: busy=%b done=%b sum=%h carry=%b, need all 0",
                     busy, done, sum, carry);
        end
`ifdef OVERFLOW_DETECT_EN
        n_vec++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset_ovf: ovf=%b, need 0", ovf);
        end
`endif
        @(negedge clock);
        resetn = 1'b1;
        last = '0;
        seen_done = 0;
        for (int k = 0; k < int'(W) + 2; k++) begin
            @(negedge clock);
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        n_vec++;
        if (seen_done != 0) begin
            n_err++;
            $display("FAIL aborted_add: %0d active cycles after reset, need 0", seen_done);
        end
        run_add(8'h0F, 8'h0F, 1'b0, -1);
    endtask

    task automatic test_overflow();
        run_add(8'h7F, 8'h01, 1'b0, -1);
        run_add(8'h80, 8'h80, 1'b0, -1);
        run_add(8'h7F, 8'h00, 1'b1, -1);
    endtask

    task automatic test_width1();
        logic [1:0] r;
        for (int i = 0; i < 8; i++) begin
            r = {1'b0, 1'(i)} + {1'b0, 1'(i >> 1)} + {1'b0, 1'(i >> 2)};
            @(negedge clock);
            s1_start = 1'b1; s1_a = 1'(i); s1_b = 1'(i >> 1); s1_c = 1'(i >> 2);
            @(posedge clock);
            @(negedge clock);
            s1_start = 1'b0;
            n_vec++;
            if (s1_busy !== 1'b1 || s1_done !== 1'b0) begin
                n_err++;
                $display("FAIL w1_busy i=%0d: busy=%b done=%b, need 1 0", i, s1_busy, s1_done);
            end
            @(posedge clock);
            @(negedge clock);
            n_vec++;
            if (s1_done !== 1'b1 || s1_sum !== r[0] || s1_carry !== r[1]) begin
                n_err++;
                $display("FAIL w1_result i=%0d: done=%b sum=%b carry=%b, need 1 %b %b",
                         i, s1_done, s1_sum, s1_carry, r[0], r[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_add();
        test_overflow();
        test_width1();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, need 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
